fb_mem_arbiter: RTL
===================

Name: fb_mem_arbiter

Overview:
- Shares the single SDRAM frame-buffer port between two requesters: the VGA scan-out line prefetcher (burst reads) and the pixel writer (single-word writes).
- Sits between the VGA pipeline / pixel writer and the SDRAM controller.
- Video has priority; an anti-starvation counter guarantees the writer forward progress.

Parameters:
- AW, 22, address width (words)
- DW, 16, data width
- LW, 8, burst-length field width
- STARVE_MAX, 64, writer wait cycles before it overrides video priority

Ports:
- iCLK  input  1  system clock (memory clock domain)
- iRESETn  input  1  asynchronous active-low reset
- iVID_REQ  input  1  video burst-read request (level; held until oVID_GNT)
- iVID_ADDR  input  AW  burst start address
- iVID_LEN  input  LW  burst length in words; 0 is treated as 1
- oVID_GNT  output  1  one-cycle pulse: video request captured
- oVID_RDATA  output  DW  read data to video
- oVID_RVALID  output  1  read data valid
- oVID_DONE  output  1  one-cycle pulse on the last beat of a burst
- iWR_REQ  input  1  write request (level; held until oWR_ACK)
- iWR_ADDR  input  AW  write address
- iWR_DATA  input  DW  write data
- oWR_ACK  output  1  one-cycle pulse: write accepted by memory
- oMEM_ADDR  output  AW  memory address
- oMEM_READ  output  1  memory read command
- oMEM_WRITE  output  1  memory write command
- oMEM_WDATA  output  DW  memory write data
- oMEM_BURSTCOUNT  output  LW  burst length for the read command
- iMEM_WAITREQUEST  input  1  memory stall; a command is accepted on an edge where this is low
- iMEM_RDATA  input  DW  memory read data
- iMEM_RDATAVALID  input  1  memory read data valid
- oBUSY  output  1  high whenever the arbiter is not in IDLE

Behaviour:
- Reset (asynchronous, iRESETn low): state IDLE. All outputs are 0. Starvation counter and beat counter are 0.
- States: IDLE, RD_CMD, RD_DATA, WR_CMD.
- IDLE priority, evaluated each cycle:
  - (1) iWR_REQ && starve_cnt==STARVE_MAX -> WR_CMD
  - (2) iVID_REQ -> RD_CMD
  - (3) iWR_REQ -> WR_CMD
  - A requester's REQ is ignored in any cycle where its own GNT/ACK is high. This prevents double service while the requester is dropping REQ.
- IDLE->RD_CMD edge:
  - Latch iVID_ADDR into oMEM_ADDR, and LEN (0 becomes 1) into oMEM_BURSTCOUNT and the beat counter.
  - oMEM_READ goes to 1.
  - oVID_GNT is 1 for the first RD_CMD cycle only.
- RD_CMD: oMEM_READ, address and burstcount are held stable until an edge with iMEM_WAITREQUEST low. At that edge oMEM_READ goes to 0 and the state moves to RD_DATA.
- RD_DATA:
  - Each iMEM_RDATAVALID beat is registered to oVID_RDATA/oVID_RVALID with 1-cycle latency, and the beat counter decrements.
  - On the final beat, oVID_DONE pulses in the same cycle as the final oVID_RVALID, and the state returns to IDLE.
  - There is no timeout; the memory must return exactly BURSTCOUNT beats.
- IDLE->WR_CMD edge: latch iWR_ADDR/iWR_DATA into oMEM_ADDR/oMEM_WDATA; oMEM_WRITE goes to 1.
- WR_CMD: the write command is held until an edge with iMEM_WAITREQUEST low. At that edge:
  - oMEM_WRITE goes to 0.
  - oWR_ACK pulses for the next cycle.
  - The state returns to IDLE and starve_cnt clears.
- Starvation counter:
  - Increments each cycle in which iWR_REQ is high, the state is not WR_CMD and oWR_ACK is low.
  - Saturates at STARVE_MAX.
  - Clears when a write is granted.
- Idle-cycle rule: oMEM_READ and oMEM_WRITE are never both high. Both are 0 in IDLE and RD_DATA.
- Stray data: iMEM_RDATAVALID outside RD_DATA is ignored, and oVID_RVALID stays 0.
- Reset mid-burst: immediate return to IDLE with all outputs cleared. Beats still in flight afterwards are ignored by the stray-data rule.
- Simultaneous requests from IDLE: video wins unless the starvation counter is saturated.

Test Plan:
- Single write: iWR_REQ with ADDR=0x00010, DATA=0xA5A5, WAITREQUEST low -> oMEM_WRITE high for 1 cycle with ADDR=0x00010 and WDATA=0xA5A5, then oWR_ACK 1-cycle pulse; exactly one write issued.
- Video burst: iVID_LEN=8, ADDR=0x01000, WAITREQUEST high for 3 cycles -> oMEM_READ held for 4 cycles with BURSTCOUNT=8; 8 RDATAVALID beats give 8 oVID_RVALID one cycle later; oVID_DONE on the 8th; back to IDLE.
- Simultaneous requests with starve_cnt=0: video granted first; the write is issued immediately after the burst's DONE.
- Starvation: video requests back-to-back 16-beat bursts while the writer waits; once the writer has waited 64 cycles, the next IDLE grants the write ahead of a pending video request.
- LEN=0: BURSTCOUNT=1; one beat returned; DONE pulses on that beat.
- Reset asserted after the 3rd of 8 beats: outputs go to 0 asynchronously; the remaining 5 beats after release produce no oVID_RVALID; a new write then completes normally.

Source files
------------

// File: rtl/fb_mem_arbiter.sv
// Shares the SDRAM frame-buffer port: video burst reads have priority, pixel writes win once starved.
// Commands are registered (1 cycle to issue), read beats forwarded 1 cycle late; waitrequest stalls the held command.
module fb_mem_arbiter #(
  parameter int AW         = 22,
  parameter int DW         = 16,
  parameter int LW         = 8,
  parameter int STARVE_MAX = 64
) (
  input  logic          iCLK,
  input  logic          iRESETn,
  input  logic          iVID_REQ,
  input  logic [AW-1:0] iVID_ADDR,
  input  logic [LW-1:0] iVID_LEN,
  output logic          oVID_GNT,
  output logic [DW-1:0] oVID_RDATA,
  output logic          oVID_RVALID,
  output logic          oVID_DONE,
  input  logic          iWR_REQ,
  input  logic [AW-1:0] iWR_ADDR,
  input  logic [DW-1:0] iWR_DATA,
  output logic          oWR_ACK,
  output logic [AW-1:0] oMEM_ADDR,
  output logic          oMEM_READ,
  output logic          oMEM_WRITE,
  output logic [DW-1:0] oMEM_WDATA,
  output logic [LW-1:0] oMEM_BURSTCOUNT,
  input  logic          iMEM_WAITREQUEST,
  input  logic [DW-1:0] iMEM_RDATA,
  input  logic          iMEM_RDATAVALID,
  output logic          oBUSY
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_CMD  = 2'd1;
  localparam logic [1:0] S_RD_DATA = 2'd2;
  localparam logic [1:0] S_WR_CMD  = 2'd3;

  logic [1:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [LW-1:0] r_bc;
  logic [LW-1:0] r_beats;
  logic          r_read;
  logic          r_write;
  logic          r_vid_gnt;
  logic          r_wr_ack;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;
  logic          r_done;
  logic [SW-1:0] r_starve;

  logic          w_idle;
  logic          w_vid_req;
  logic          w_wr_req;
  logic          w_starved;
  logic          w_go_wr;
  logic          w_go_rd;
  logic [LW-1:0] w_len;

  // A requester still showing REQ during its own GNT/ACK cycle is dropping it, not asking again.
  assign w_idle    = (r_state == S_IDLE);
  assign w_vid_req = iVID_REQ & ~r_vid_gnt;
  assign w_wr_req  = iWR_REQ & ~r_wr_ack;
  assign w_starved = (r_starve == SW'(STARVE_MAX));
  assign w_go_wr   = w_idle & w_wr_req & (w_starved | ~w_vid_req);
  assign w_go_rd   = w_idle & w_vid_req & ~(w_wr_req & w_starved);
  assign w_len     = (iVID_LEN == '0) ? LW'(1) : iVID_LEN;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_bc      <= '0;
      r_beats   <= '0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_vid_gnt <= 1'b0;
      r_wr_ack  <= 1'b0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_vid_gnt <= 1'b0;
      r_wr_ack  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go_wr) begin
            r_addr  <= iWR_ADDR;
            r_wdata <= iWR_DATA;
            r_write <= 1'b1;
            r_state <= S_WR_CMD;
          end else if (w_go_rd) begin
            r_addr    <= iVID_ADDR;
            r_bc      <= w_len;
            r_beats   <= w_len;
            r_read    <= 1'b1;
            r_vid_gnt <= 1'b1;
            r_state   <= S_RD_CMD;
          end
        end
        S_RD_CMD: begin
          if (!iMEM_WAITREQUEST) begin
            r_read  <= 1'b0;
            r_state <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          // Data outside this state is stray and never reaches the video side.
          if (iMEM_RDATAVALID) begin
            r_rdata  <= iMEM_RDATA;
            r_rvalid <= 1'b1;
            r_beats  <= r_beats - LW'(1);
            if (r_beats == LW'(1)) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_WR_CMD: begin
          if (!iMEM_WAITREQUEST) begin
            r_write  <= 1'b0;
            r_wr_ack <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_starve <= '0;
    end else if (w_go_wr || r_state == S_WR_CMD) begin
      r_starve <= '0;
    end else if (iWR_REQ && !r_wr_ack && !w_starved) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  assign oVID_GNT        = r_vid_gnt;
  assign oVID_RDATA      = r_rdata;
  assign oVID_RVALID     = r_rvalid;
  assign oVID_DONE       = r_done;
  assign oWR_ACK         = r_wr_ack;
  assign oMEM_ADDR       = r_addr;
  assign oMEM_READ       = r_read;
  assign oMEM_WRITE      = r_write;
  assign oMEM_WDATA      = r_wdata;
  assign oMEM_BURSTCOUNT = r_bc;
  assign oBUSY           = ~w_idle;

endmodule
